// File: rtl/lcd_bus_receiver.sv
// Listening end of the 4-bit character-LCD bus: synchronises the pins, pairs nibbles into bytes
// and tracks the DDRAM cursor. Define LCD_RX_TIMEOUT_EN to enable the inter-nibble timeout.
module lcd_bus_receiver #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned NIBBLE_TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SF_D,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  output logic [7:0] BYTE_OUT,
  output logic       BYTE_RS,
  output logic       BYTE_VALID,
  output logic       INIT_DONE,
  output logic [6:0] DDRAM_ADDR,
  output logic       PROTO_ERR
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (NIBBLE_TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("NIBBLE_TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {StInit, StHigh, StLow} state_e;

  // Input synchronisers; the highest index is the synchronised output.
  logic [SYNC_STAGES-1:0][3:0] d_sync_q;
  logic [SYNC_STAGES-1:0]      e_sync_q;
  logic [SYNC_STAGES-1:0]      rs_sync_q;
  logic [SYNC_STAGES-1:0]      rw_sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_sync_q  <= '0;
      e_sync_q  <= '0;
      rs_sync_q <= '0;
      rw_sync_q <= '0;
    end else begin
      d_sync_q  <= {d_sync_q[SYNC_STAGES-2:0], SF_D};
      e_sync_q  <= {e_sync_q[SYNC_STAGES-2:0], LCD_E};
      rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], LCD_RS};
      rw_sync_q <= {rw_sync_q[SYNC_STAGES-2:0], LCD_RW};
    end
  end

  logic       e_s;
  logic       rw_s;
  logic       e_prev_q;
  logic       evt_d;
  logic       evt_q;
  logic [3:0] evt_nib_q;
  logic       evt_rs_q;

  assign e_s   = e_sync_q[SYNC_STAGES-1];
  assign rw_s  = rw_sync_q[SYNC_STAGES-1];
  // Read cycles are dropped here so they never reach the FSM.
  assign evt_d = e_prev_q & ~e_s & ~rw_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_prev_q  <= 1'b0;
      evt_q     <= 1'b0;
      evt_nib_q <= 4'h0;
      evt_rs_q  <= 1'b0;
    end else begin
      e_prev_q  <= e_s;
      evt_q     <= evt_d;
      if (evt_d) begin
        evt_nib_q <= d_sync_q[SYNC_STAGES-1];
        evt_rs_q  <= rs_sync_q[SYNC_STAGES-1];
      end
    end
  end

  state_e     state_q, state_d;
  logic [3:0] held_q, held_d;
  logic       held_rs_q, held_rs_d;
  logic [7:0] data_q, data_d;
  logic       data_rs_q, data_rs_d;
  logic       valid_q, valid_d;
  logic       init_done_q, init_done_d;
  logic [6:0] addr_q, addr_d;
  logic       err_q, err_d;

`ifdef LCD_RX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(NIBBLE_TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(NIBBLE_TIMEOUT_CYC - 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  function automatic logic [6:0] next_addr(input logic [6:0] addr, input logic rs,
                                           input logic [7:0] b);
    logic [6:0] a;
    a = addr;
    if (rs) begin
      // Two-line display: line 1 ends at 0x27, line 2 at 0x67.
      if (addr == 7'h27)      a = 7'h40;
      else if (addr == 7'h67) a = 7'h00;
      else                    a = addr + 7'd1;
    end else if (b[7]) begin
      a = b[6:0];
    end else if (b == 8'h01 || b == 8'h02 || b == 8'h03) begin
      a = 7'h00;
    end
    return a;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StInit;
      held_q      <= 4'h0;
      held_rs_q   <= 1'b0;
      data_q      <= 8'h00;
      data_rs_q   <= 1'b0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
      addr_q      <= 7'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      held_rs_q   <= held_rs_d;
      data_q      <= data_d;
      data_rs_q   <= data_rs_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    held_rs_d   = held_rs_q;
    data_d      = data_q;
    data_rs_d   = data_rs_q;
    valid_d     = 1'b0;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    err_d       = err_q;
`ifdef LCD_RX_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StInit: begin
        // 8-bit-mode nibbles: 0x3 keeps waiting, 0x2 switches to 4-bit mode.
        if (evt_q && !evt_rs_q && evt_nib_q == 4'h2) begin
          state_d     = StHigh;
          init_done_d = 1'b1;
        end
      end
      StHigh: begin
        if (evt_q) begin
          held_d    = evt_nib_q;
          held_rs_d = evt_rs_q;
          state_d   = StLow;
`ifdef LCD_RX_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      StLow: begin
        if (evt_q) begin
          if (evt_rs_q == held_rs_q) begin
            data_d    = {held_q, evt_nib_q};
            data_rs_d = evt_rs_q;
            valid_d   = 1'b1;
            addr_d    = next_addr(addr_q, evt_rs_q, {held_q, evt_nib_q});
            state_d   = StHigh;
          end else begin
            // RS changed mid-pair: the new nibble starts a fresh pair.
            err_d     = 1'b1;
            held_d    = evt_nib_q;
            held_rs_d = evt_rs_q;
`ifdef LCD_RX_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
`ifdef LCD_RX_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StInit;
    endcase
  end

  assign BYTE_OUT   = data_q;
  assign BYTE_RS    = data_rs_q;
  assign BYTE_VALID = valid_q;
  assign INIT_DONE  = init_done_q;
  assign DDRAM_ADDR = addr_q;
  assign PROTO_ERR  = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: expected bytes are queued as nibbles are driven and
// compared when BYTE_VALID pulses.
module tb_lcd_bus_receiver;

  localparam int unsigned Sync = 2;
  localparam int unsigned Tmo  = 200;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] SF_D;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] BYTE_OUT;
  logic       BYTE_RS;
  logic       BYTE_VALID;
  logic       INIT_DONE;
  logic [6:0] DDRAM_ADDR;
  logic       PROTO_ERR;

  lcd_bus_receiver #(
    .SYNC_STAGES       (Sync),
    .NIBBLE_TIMEOUT_CYC(Tmo)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SF_D      (SF_D),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .BYTE_OUT  (BYTE_OUT),
    .BYTE_RS   (BYTE_RS),
    .BYTE_VALID(BYTE_VALID),
    .INIT_DONE (INIT_DONE),
    .DDRAM_ADDR(DDRAM_ADDR),
    .PROTO_ERR (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // {rs, byte, addr}
  logic [15:0] exp_q[$];
  logic [6:0]  model_addr;
  logic        prev_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST && BYTE_VALID) begin
      check("valid_back_to_back", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {24'd0, BYTE_OUT}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("byte_rs", {31'd0, BYTE_RS}, {31'd0, e[15]});
        check("byte_out", {24'd0, BYTE_OUT}, {24'd0, e[14:7]});
        check("ddram_addr", {25'd0, DDRAM_ADDR}, {25'd0, e[6:0]});
      end
    end
    prev_valid = BYTE_VALID;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_nibble(input logic [3:0] nib, input logic rs, input logic rw,
                             input bit measure);
    int cyc;
    bit seen;
    @(posedge CLK); #1;
    SF_D = nib; LCD_RS = rs; LCD_RW = rw; LCD_E = 1'b1;
    repeat (4) @(posedge CLK);
    #1 LCD_E = 1'b0;
    if (measure) begin
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 12) begin
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        if (BYTE_VALID) seen = 1;
      end
      check("latency", cyc, Sync + 2);
    end
    repeat (6) @(posedge CLK);
    LCD_RW = 1'b0;
  endtask

  function automatic logic [6:0] model_next(input logic [6:0] a, input logic rs,
                                            input logic [7:0] b);
    if (rs)
      return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : 7'(a + 1);
    if (b[7]) return b[6:0];
    if (b >= 8'h01 && b <= 8'h03) return 7'h00;
    return a;
  endfunction

  task automatic expect_byte(input logic [7:0] b, input logic rs);
    model_addr = model_next(model_addr, rs, b);
    exp_q.push_back({rs, b, model_addr});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input bit measure);
    send_nibble(b[7:4], rs, 1'b0, 1'b0);
    expect_byte(b, rs);
    send_nibble(b[3:0], rs, 1'b0, measure);
  endtask

  task automatic do_init();
    send_nibble(4'h3, 1'b0, 1'b0, 1'b0);
    send_nibble(4'h3, 1'b0, 1'b0, 1'b0);
    send_nibble(4'h3, 1'b0, 1'b0, 1'b0);
    send_nibble(4'h2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("rst_byte_out", {24'd0, BYTE_OUT}, 32'd0);
    check("rst_byte_rs", {31'd0, BYTE_RS}, 32'd0);
    check("rst_byte_valid", {31'd0, BYTE_VALID}, 32'd0);
    check("rst_init_done", {31'd0, INIT_DONE}, 32'd0);
    check("rst_ddram_addr", {25'd0, DDRAM_ADDR}, 32'd0);
    check("rst_proto_err", {31'd0, PROTO_ERR}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    model_addr = 7'h00;
    exp_q.delete();
  endtask

  initial begin
    RST = 1'b1; SF_D = 4'h0; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
    model_addr = 7'h00;
    prev_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset mid-pair drops the held nibble; re-init produces no bytes.
    do_init();
    check("init_done_first", {31'd0, INIT_DONE}, 32'd1);
    send_nibble(4'h4, 1'b0, 1'b0, 1'b0);
    apply_reset();
    do_init();
    check("init_done_after_reset", {31'd0, INIT_DONE}, 32'd1);

    // Function set and clear display, with latency measured on each pulse.
    send_byte(8'h28, 1'b0, 1'b1);
    send_byte(8'h01, 1'b0, 1'b1);

    // Address wraps at the end of each display line.
    send_byte(8'hA7, 1'b0, 1'b0);
    send_byte(8'h41, 1'b1, 1'b0);
    check("addr_wrap_line1", {25'd0, DDRAM_ADDR}, 32'h40);
    send_byte(8'hE7, 1'b0, 1'b0);
    send_byte(8'h42, 1'b1, 1'b0);
    check("addr_wrap_line2", {25'd0, DDRAM_ADDR}, 32'h00);

    // Read cycles between nibbles are ignored, even with a different RS.
    send_nibble(4'h4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_nibble(4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
    expect_byte(8'h48, 1'b1);
    send_nibble(4'h8, 1'b1, 1'b0, 1'b0);
    check("rw_proto_err", {31'd0, PROTO_ERR}, 32'd0);

    // RS mismatch mid-pair: sticky error, new nibble starts the pair.
    send_nibble(4'h4, 1'b1, 1'b0, 1'b0);
    send_nibble(4'h1, 1'b0, 1'b0, 1'b0);
    check("mismatch_proto_err", {31'd0, PROTO_ERR}, 32'd1);
    check("byte_out_held", {24'd0, BYTE_OUT}, 32'h48);
    expect_byte(8'h15, 1'b0);
    send_nibble(4'h5, 1'b0, 1'b0, 1'b0);
    check("proto_err_sticky", {31'd0, PROTO_ERR}, 32'd1);

    apply_reset();
    do_init();
`ifdef LCD_RX_TIMEOUT_EN
    send_nibble(4'h3, 1'b1, 1'b0, 1'b0);
    repeat (Tmo + 20) @(posedge CLK);
    #1 check("timeout_proto_err", {31'd0, PROTO_ERR}, 32'd1);
    send_nibble(4'h4, 1'b1, 1'b0, 1'b0);
    expect_byte(8'h41, 1'b1);
    send_nibble(4'h1, 1'b1, 1'b0, 1'b0);
`else
    send_nibble(4'h3, 1'b1, 1'b0, 1'b0);
    repeat (Tmo + 20) @(posedge CLK);
    #1 check("no_timeout_proto_err", {31'd0, PROTO_ERR}, 32'd0);
    expect_byte(8'h34, 1'b1);
    send_nibble(4'h4, 1'b1, 1'b0, 1'b0);
`endif
    repeat (4) @(posedge CLK);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Listening end of the 4-bit character-LCD bus (SF_D[11:8], LCD_E, LCD_RS, LCD_RW) driven by the team's LCD writer.
- Synchronises the bus, detects LCD_E falling edges, tracks the power-on nibble sequence, and pairs high/low nibbles into bytes tagged with RS.
- Tracks the DDRAM address cursor.
- Used as an on-chip bus monitor and as the checker in LCD testbenches.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser (minimum 2).
- NIBBLE_TIMEOUT_CYC, 50000, maximum CLK cycles between the high and low nibble of a pair (1 ms at 50 MHz).

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- SF_D  input  4  LCD data nibble, bits [11:8].
- LCD_E  input  1  LCD enable strobe; data is latched on its falling edge.
- LCD_RS  input  1  register select: 0 = command, 1 = data.
- LCD_RW  input  1  read/write: 1 = read cycle, ignored.
- BYTE_OUT  output  8  last assembled byte.
- BYTE_RS  output  1  RS value belonging to BYTE_OUT.
- BYTE_VALID  output  1  one-cycle pulse: a new byte is on BYTE_OUT/BYTE_RS.
- INIT_DONE  output  1  high once 4-bit mode has been entered.
- DDRAM_ADDR  output  7  tracked cursor address.
- PROTO_ERR  output  1  sticky protocol-error flag; cleared only by RST.

Behaviour:
- Reset (async, RST=1): FSM goes to INIT. BYTE_OUT=0x00, BYTE_RS=0, BYTE_VALID=0, INIT_DONE=0, DDRAM_ADDR=0x00, PROTO_ERR=0, held nibble cleared, timeout counter cleared, synchroniser flops cleared to 0. Reset mid-pair drops the held nibble with no output.
- Synchronisation: SF_D, LCD_E, LCD_RS and LCD_RW each pass through SYNC_STAGES flops.
- Edge event: the cycle in which synchronised E was 1 last cycle and is 0 now. Nibble and RS are taken from the synchronised values in that same cycle.
- Events with synchronised RW=1 are discarded and change no state.
- FSM states:
  - INIT: each event is a standalone 8-bit-mode nibble.
    - RS=0, nibble 0x3: stay in INIT.
    - RS=0, nibble 0x2: go to HIGH and set INIT_DONE=1.
    - Any other nibble: ignored, no error.
  - HIGH: an event stores the nibble as bits [7:4] plus its RS, clears the timeout counter, goes to LOW.
  - LOW, event with RS equal to the held RS: BYTE_OUT={held,nibble}, BYTE_RS=RS, BYTE_VALID=1 on the next cycle; go to HIGH.
  - LOW, event with RS different from the held RS: drop the held nibble, set PROTO_ERR, store the current nibble as the new high nibble, stay in LOW, restart the timeout.
  - LOW, timeout counter reaches NIBBLE_TIMEOUT_CYC-1 with no event: drop the held nibble, set PROTO_ERR, go to HIGH.
- Latency: SF_D/LCD_E pin change to BYTE_VALID is SYNC_STAGES+2 CLK cycles.
- BYTE_VALID is never high on two consecutive cycles. BYTE_OUT/BYTE_RS hold until the next valid byte.
- DDRAM_ADDR update, in the same cycle as BYTE_VALID:
  - Command 0x01 or 0x02/0x03: address becomes 0x00.
  - Command with bit7=1: address becomes byte[6:0].
  - Data byte: address increments by 1, with wrap 0x27->0x40 and 0x67->0x00.
  - Other commands (including entry-mode set) leave the address unchanged.
  - Only increment mode is tracked.
- Events arriving in HIGH/LOW while INIT_DONE=1 are never treated as init nibbles. A repeated function set 0x28 is an ordinary command byte.

Optional Feature:
- Macro: LCD_RX_TIMEOUT_EN.
- Defined: NIBBLE_TIMEOUT_CYC counter present; LOW-state timeout behaves as in Behaviour.
- Undefined: no counter. LOW waits indefinitely for the second nibble, and PROTO_ERR is set only by an RS mismatch.

Test Plan:
- Assert RST mid-pair (after high nibble 0x4) -> all outputs 0, FSM in INIT, INIT_DONE=0; the next nibbles 0x3,0x3,0x3,0x2 (RS=0) -> INIT_DONE=1 and no BYTE_VALID pulses.
- After init, send nibbles 0x2,0x8 RS=0, then 0x0,0x1 RS=0 -> two pulses: BYTE_OUT=0x28 BYTE_RS=0, then 0x01 BYTE_RS=0 with DDRAM_ADDR=0x00; each pulse appears SYNC_STAGES+2 cycles after the E falling edge.
- Command 0xA7 (sets address 0x27), then data 0x41 (RS=1) -> BYTE_OUT=0x41 BYTE_RS=1, DDRAM_ADDR=0x40; command 0xE7 (address 0x67) then data 0x42 -> DDRAM_ADDR=0x00.
- High nibble 0x4 RS=1, then nibble 0x1 RS=0 -> no pulse, PROTO_ERR=1; following nibble 0x5 RS=0 -> BYTE_OUT=0x15 BYTE_RS=0.
- With LCD_RX_TIMEOUT_EN defined: high nibble 0x3, idle NIBBLE_TIMEOUT_CYC cycles, then nibbles 0x4,0x1 RS=1 -> PROTO_ERR=1, single pulse BYTE_OUT=0x41.
- E pulses with LCD_RW=1 and random SF_D interleaved between the nibbles of 0x48 RS=1 -> exactly one pulse, BYTE_OUT=0x48; PROTO_ERR unchanged.
